// File: rtl/game_sequencer.sv
// Two-player dice game sequencer: IDLE -> ROLL -> HOLD -> NEXT ... -> DONE.
// Each player rolls once per round for ROUNDS rounds. Scores accumulate and
// saturate at 15.
// Optional build macro AUTO_STOP_EN: while in ROLL, a tick counter stops the
// roll automatically after ROLL_TICKS cycles. When the macro is undefined, the
// roll runs until btn is pressed, with no time limit.
module game_sequencer #(
  parameter int ROUNDS     = 3,
  parameter int ROLL_TICKS = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       times,
  output logic       is_final,
  output logic       is_finish,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] dice,
  output logic       player,
  output logic [1:0] round
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ROLL = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] LAST_RND = 2'(ROUNDS - 1);

  if (ROUNDS < 1 || ROUNDS > 3 || ROLL_TICKS < 1) begin : g_bad_param
    $error("game_sequencer: ROUNDS must be 1..3 and ROLL_TICKS >= 1");
  end

  logic [2:0] state, state_nx;
  logic       stop;      // end the current roll this cycle
  logic [3:0] cur_score;
  logic [4:0] sum;
  logic [3:0] sat_score;

`ifdef AUTO_STOP_EN
  localparam int TW = (ROLL_TICKS > 1) ? $clog2(ROLL_TICKS) : 1;
  logic [TW-1:0] tick;

  // A timeout and a btn press in the same cycle collapse into a single stop.
  assign stop = btn || (tick == TW'(ROLL_TICKS - 1));

  // Cycles spent in the current roll. The counter holds 0 outside ROLL, so
  // every roll starts counting from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         tick <= '0;
    else if (state == S_ROLL && !stop) tick <= tick + TW'(1);
    else                              tick <= '0;
  end
`else
  assign stop = btn;
`endif

  // Add the frozen face value to the active player's score, clamped to 15.
  always_comb begin
    cur_score = player ? score2 : score1;
    sum       = {1'b0, cur_score} + {2'b00, dice};
    sat_score = sum[4] ? 4'hF : sum[3:0];
  end

  // Next-state logic. btn only has an effect in IDLE, ROLL and DONE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (btn) state_nx = S_ROLL;
      S_ROLL:  if (stop) state_nx = S_HOLD;
      S_HOLD:  state_nx = S_NEXT;
      S_NEXT:  state_nx = (player && round == LAST_RND) ? S_DONE : S_ROLL;
      S_DONE:  if (btn) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and game datapath. times is registered from the next
  // state, so it is high exactly for the cycles spent in ROLL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      times  <= 1'b0;
      score1 <= '0;
      score2 <= '0;
      dice   <= '0;
      player <= 1'b0;
      round  <= '0;
    end else begin
      state <= state_nx;
      times <= (state_nx == S_ROLL);
      case (state)
        S_IDLE: if (btn) dice <= 3'd1;
        S_ROLL: if (!stop) dice <= (dice == 3'd6) ? 3'd1 : dice + 3'd1;
        S_HOLD: begin
          if (player) score2 <= sat_score;
          else        score1 <= sat_score;
        end
        S_NEXT: begin
          player <= ~player;
          // On the final NEXT the round index stays at the last round.
          if (player && round != LAST_RND) round <= round + 2'd1;
          if (state_nx == S_ROLL) dice <= 3'd1;
        end
        S_DONE: begin
          if (btn) begin
            score1 <= '0;
            score2 <= '0;
            dice   <= '0;
            player <= 1'b0;
            round  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign is_finish = (state == S_DONE);
  assign is_final  = (state == S_DONE) || (state != S_IDLE && round == LAST_RND);

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer (ROUNDS=3, ROLL_TICKS=10).
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic       times, is_final, is_finish, player;
  logic [3:0] score1, score2;
  logic [2:0] dice;
  logic [1:0] round;

  int n_chk = 0;
  int n_fail = 0;

  game_sequencer #(.ROUNDS(3), .ROLL_TICKS(10)) dut (
    .clk(clk), .rst(rst), .btn(btn), .times(times), .is_final(is_final),
    .is_finish(is_finish), .score1(score1), .score2(score2), .dice(dice),
    .player(player), .round(round)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press();
    btn = 1'b1; step(1); btn = 1'b0;
  endtask

  task automatic do_reset();
    btn = 1'b0; rst = 1'b0; step(2); rst = 1'b1; step(1);
  endtask

  // Wait in ROLL until the die shows v, then stop it there. Afterwards the
  // design is in HOLD.
  task automatic roll_stop(input int v);
    int k = 0;
    while (dice !== 3'(v) && k < 12) begin step(1); k++; end
    n_chk++;
    if (k >= 12) begin n_fail++; $display("FAIL roll_wait: dice %0d never reached %0d", dice, v); end
    press();
  endtask

  task automatic test_reset();
    btn = 1'b0; rst = 1'b0; step(2);
    n_chk++; if (times !== 1'b0)     begin n_fail++; $display("FAIL rst_times: got %0d want 0", times); end
    n_chk++; if (is_final !== 1'b0)  begin n_fail++; $display("FAIL rst_final: got %0d want 0", is_final); end
    n_chk++; if (is_finish !== 1'b0) begin n_fail++; $display("FAIL rst_finish: got %0d want 0", is_finish); end
    n_chk++; if (score1 !== 4'd0 || score2 !== 4'd0) begin n_fail++; $display("FAIL rst_scores: got %0d/%0d want 0/0", score1, score2); end
    n_chk++; if (dice !== 3'd0)      begin n_fail++; $display("FAIL rst_dice: got %0d want 0", dice); end
    n_chk++; if (player !== 1'b0 || round !== 2'd0) begin n_fail++; $display("FAIL rst_player_round: got %0d/%0d want 0/0", player, round); end
    rst = 1'b1; step(1);
  endtask

  task automatic test_first_roll();
    do_reset();
    press();                 // IDLE -> ROLL, first face is 1
    n_chk++; if (dice !== 3'd1 || times !== 1'b1) begin n_fail++; $display("FAIL roll_start: dice %0d times %0d want 1/1", dice, times); end
    step(2);                 // third ROLL cycle
    n_chk++; if (dice !== 3'd3) begin n_fail++; $display("FAIL roll_step: got %0d want 3", dice); end
    press();                 // stop on 3 -> HOLD
    n_chk++; if (dice !== 3'd3 || times !== 1'b0) begin n_fail++; $display("FAIL hold_freeze: dice %0d times %0d want 3/0", dice, times); end
    n_chk++; if (score1 !== 4'd0) begin n_fail++; $display("FAIL hold_score: got %0d want 0", score1); end
    step(1);                 // NEXT: score is visible
    n_chk++; if (score1 !== 4'd3) begin n_fail++; $display("FAIL next_score1: got %0d want 3", score1); end
    step(1);                 // back in ROLL for player 2
    n_chk++; if (player !== 1'b1 || round !== 2'd0 || times !== 1'b1) begin n_fail++; $display("FAIL p2_turn: player %0d round %0d times %0d want 1/0/1", player, round, times); end
  endtask

  task automatic test_full_game();
    int exp;
    do_reset();
    press();
    for (int i = 0; i < 6; i++) begin
      roll_stop(6);
      n_chk++; if (is_final !== (i >= 4)) begin n_fail++; $display("FAIL final_flag[%0d]: got %0d want %0d", i, is_final, (i >= 4)); end
      n_chk++; if (is_finish !== 1'b0) begin n_fail++; $display("FAIL finish_early[%0d]: got %0d want 0", i, is_finish); end
      step(1);
      exp = 6 * (i / 2 + 1); if (exp > 15) exp = 15;
      if (i % 2 == 0) begin
        n_chk++; if (score1 !== 4'(exp)) begin n_fail++; $display("FAIL game_score1[%0d]: got %0d want %0d", i, score1, exp); end
      end else begin
        n_chk++; if (score2 !== 4'(exp)) begin n_fail++; $display("FAIL game_score2[%0d]: got %0d want %0d", i, score2, exp); end
      end
      step(1);
    end
    n_chk++; if (is_finish !== 1'b1 || is_final !== 1'b1 || times !== 1'b0) begin n_fail++; $display("FAIL done_flags: finish %0d final %0d times %0d want 1/1/0", is_finish, is_final, times); end
    n_chk++; if (score1 !== 4'd15 || score2 !== 4'd15) begin n_fail++; $display("FAIL done_scores: got %0d/%0d want 15/15", score1, score2); end
    step(3);
    n_chk++; if (dice !== 3'd6 || round !== 2'd2 || is_finish !== 1'b1) begin n_fail++; $display("FAIL done_hold: dice %0d round %0d finish %0d want 6/2/1", dice, round, is_finish); end
  endtask

  // Continues from DONE, where the full game ended.
  task automatic test_done_clear();
    press();
    n_chk++; if (score1 !== 4'd0 || score2 !== 4'd0 || dice !== 3'd0) begin n_fail++; $display("FAIL clear_vals: s1 %0d s2 %0d dice %0d want 0/0/0", score1, score2, dice); end
    n_chk++; if (is_finish !== 1'b0 || is_final !== 1'b0 || round !== 2'd0 || player !== 1'b0) begin n_fail++; $display("FAIL clear_flags: fin %0d final %0d round %0d player %0d want 0s", is_finish, is_final, round, player); end
    step(2);
    n_chk++; if (times !== 1'b0 || dice !== 3'd0) begin n_fail++; $display("FAIL idle_stay: times %0d dice %0d want 0/0", times, dice); end
  endtask

  task automatic test_ignore_btn();
    do_reset();
    press();
    roll_stop(2);            // HOLD
    press();                 // btn in HOLD -> ignored, now NEXT
    n_chk++; if (times !== 1'b0 || score1 !== 4'd2) begin n_fail++; $display("FAIL ign_hold: times %0d score1 %0d want 0/2", times, score1); end
    press();                 // btn in NEXT -> ignored, now ROLL
    n_chk++; if (times !== 1'b1 || player !== 1'b1 || round !== 2'd0 || dice !== 3'd1) begin n_fail++; $display("FAIL ign_next: times %0d player %0d round %0d dice %0d want 1/1/0/1", times, player, round, dice); end
    step(1);
    n_chk++; if (times !== 1'b1 || dice !== 3'd2 || score2 !== 4'd0) begin n_fail++; $display("FAIL ign_noqueue: times %0d dice %0d score2 %0d want 1/2/0", times, dice, score2); end
  endtask

  task automatic test_reset_mid_roll();
    do_reset();
    press();
    roll_stop(4); step(2);
    roll_stop(5); step(2);   // round 1, player 1 rolling
    n_chk++; if (round !== 2'd1 || times !== 1'b1 || score2 !== 4'd5) begin n_fail++; $display("FAIL pre_rst: round %0d times %0d score2 %0d want 1/1/5", round, times, score2); end
    #2 rst = 1'b0; #1;
    n_chk++; if (times !== 1'b0 || score1 !== 4'd0 || score2 !== 4'd0 || dice !== 3'd0) begin n_fail++; $display("FAIL async_rst: times %0d s1 %0d s2 %0d dice %0d want 0s", times, score1, score2, dice); end
    n_chk++; if (round !== 2'd0 || player !== 1'b0 || is_final !== 1'b0 || is_finish !== 1'b0) begin n_fail++; $display("FAIL async_rst2: round %0d player %0d final %0d fin %0d want 0s", round, player, is_final, is_finish); end
    step(1); rst = 1'b1; step(2);
    n_chk++; if (times !== 1'b0 || dice !== 3'd0) begin n_fail++; $display("FAIL post_rst_idle: times %0d dice %0d want 0/0", times, dice); end
    press();
    n_chk++; if (times !== 1'b1 || dice !== 3'd1 || round !== 2'd0 || player !== 1'b0) begin n_fail++; $display("FAIL restart: times %0d dice %0d round %0d player %0d want 1/1/0/0", times, dice, round, player); end
  endtask

`ifdef AUTO_STOP_EN
  task automatic test_auto_stop();
    do_reset();
    press();                 // ROLL cycle 1
    step(9);                 // ROLL cycle 10
    n_chk++; if (times !== 1'b1) begin n_fail++; $display("FAIL auto_cycle10: times %0d want 1", times); end
    step(1);                 // timeout -> HOLD, face of cycle 10 is 4
    n_chk++; if (times !== 1'b0 || dice !== 3'd4) begin n_fail++; $display("FAIL auto_hold: times %0d dice %0d want 0/4", times, dice); end
    step(1);
    n_chk++; if (score1 !== 4'd4) begin n_fail++; $display("FAIL auto_score1: got %0d want 4", score1); end
    step(1);                 // ROLL cycle 1 for player 2
    step(9);                 // cycle 10
    press();                 // btn together with timeout
    n_chk++; if (times !== 1'b0 || dice !== 3'd4) begin n_fail++; $display("FAIL both_hold: times %0d dice %0d want 0/4", times, dice); end
    step(1);
    n_chk++; if (score2 !== 4'd4) begin n_fail++; $display("FAIL both_single: score2 %0d want 4", score2); end
    step(1);
    n_chk++; if (times !== 1'b1 || player !== 1'b0 || round !== 2'd1) begin n_fail++; $display("FAIL both_next: times %0d player %0d round %0d want 1/0/1", times, player, round); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_roll();
    test_full_game();
    test_done_clear();
    test_ignore_btn();
    test_reset_mid_roll();
`ifdef AUTO_STOP_EN
    test_auto_stop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter ROUNDS, default 3: rolls per player per game, legal range 1..3.
REQ-002 Parameter ROLL_TICKS, default 100000: auto-stop timeout in ROLL, in clk cycles.
REQ-003 Port clk, input, 1: rising-edge system clock.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port btn, input, 1: debounced single-cycle press pulse, synchronous to clk.
REQ-006 Port times, output, 1: high while dice spinning (state ROLL).
REQ-007 Port is_final, output, 1: high during the last round and in DONE.
REQ-008 Port is_finish, output, 1: high only in DONE.
REQ-009 Port score1 / score2, output, 4 each: accumulated scores of player 1 / player 2.
REQ-010 Port dice, output, 3: current face value 1..6; 0 only in IDLE.
REQ-011 Port player, output, 1: active player (0 = P1, 1 = P2).
REQ-012 Port round, output, 2: current round index, 0..ROUNDS-1.

Function
REQ-013 FSM states SHALL be IDLE, ROLL, HOLD, NEXT, DONE, one-hot or binary at implementer's choice.
REQ-014 IDLE: outputs per REQ-026; btn -> ROLL next cycle, dice loads 1.
REQ-015 ROLL: times=1; dice SHALL step 1,2,...,6,1 every clk cycle; tick counter SHALL increment from 0 each cycle.
REQ-016 ROLL exit: btn -> HOLD; the dice value present in the btn cycle SHALL be frozen.
REQ-017 HOLD (exactly 1 cycle): frozen dice SHALL be added to the active player's score, saturating at 15; -> NEXT.
REQ-018 NEXT (exactly 1 cycle): if player=0, player <= 1; else player <= 0 and round <= round+1; if player=1 and round=ROUNDS-1 -> DONE, else -> ROLL with tick counter cleared.
REQ-019 is_final SHALL be high whenever round = ROUNDS-1 (any state except IDLE) and in DONE.
REQ-020 DONE: is_finish=1, is_final=1, times=0, scores and dice held; btn -> IDLE, clearing scores, round, player, dice.
REQ-021 btn in HOLD or NEXT SHALL be ignored (no queuing).
REQ-022 times SHALL be registered and SHALL equal 1 exactly in cycles where state = ROLL.
REQ-023 score outputs SHALL change only on the cycle after HOLD; no other path modifies them except reset and DONE->IDLE.
REQ-024 Tie (score1 = score2) SHALL need no special handling here; winner selection belongs to the LED block.

Reset
REQ-025 rst low SHALL force state IDLE asynchronously, from any state, including mid-ROLL.
REQ-026 Reset values: times=0, is_final=0, is_finish=0, score1=0, score2=0, dice=0, player=0, round=0, tick counter=0.
REQ-027 After rst release, first btn SHALL start a fresh game; no pre-reset btn is retained.

Configuration
REQ-028 Macro AUTO_STOP_EN defined: in ROLL, tick counter reaching ROLL_TICKS-1 SHALL act as btn (-> HOLD, freeze dice); btn and timeout in the same cycle SHALL yield one stop only.
REQ-029 AUTO_STOP_EN undefined: tick counter logic SHALL be absent; ROLL exits only on btn, indefinitely.

Verification
REQ-030 Reset, btn in IDLE; btn after 3 ROLL cycles -> dice=3 frozen, score1=3 two cycles later, player=1.
REQ-031 ROUNDS=3, six rolls each stopped at dice=6 -> score1=15, score2=15 (saturated), is_final high from round=2, is_finish=1 after 6th HOLD/NEXT.
REQ-032 AUTO_STOP_EN, ROLL_TICKS=10, no btn -> HOLD entered after exactly 10 ROLL cycles; btn on cycle 10 -> single score update.
REQ-033 rst low mid-ROLL in round 1 -> all outputs zero immediately, state IDLE; next btn restarts with round=0.
REQ-034 btn pulses during HOLD and NEXT -> ignored, player/round advance once; btn in DONE -> IDLE with scores cleared.
